display_scan_ctrl: RTL

//   Upstream feeder for the registered 4-bit-to-7-segment decoder. Latches a binary

---
 rtl/display_scan_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Purpose: latch a 14-bit value, convert it to 4 BCD digits, and scan them onto a shared digit bus with active-low anodes.
// Latency: new value shows from the first scan slot after commit (load + 15 clk); each anode update lags its digit by 1 clk.
// Backpressure: none; load is taken only while busy is low, and a load during busy is dropped, not queued.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  digit,
    output logic [3:0]  AN
);

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state, state_nxt;
    logic [13:0]   shreg;
    logic [15:0]   scratch;
    logic [15:0]   adj;
    logic [15:0]   bcd;
    logic [3:0]    bitcnt;

    logic [CW-1:0] cnt;
    logic          tick;
    logic          tick_d;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          blank_r;
    logic          blank_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (bitcnt == 4'd0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < 4; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            scratch  <= '0;
            bcd      <= '0;
            bitcnt   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= (value > 14'd9999) ? 14'd9999 : value;
                        overflow <= (value > 14'd9999);
                        scratch  <= '0;
                        bitcnt   <= 4'd13;
                    end
                end
                CONV: begin
                    scratch <= {adj[14:0], shreg[13]};
                    shreg   <= {shreg[12:0], 1'b0};
                    bitcnt  <= bitcnt - 4'd1;
                end
                COMMIT:  bcd <= scratch;
                default: ;
            endcase
        end
    end

    assign tick    = (cnt == CNT_MAX);
    assign idx_nxt = idx + 2'd1;

    // Digit k is blanked when it and every more significant nibble are zero.
    always_comb begin
        blank_nxt = 1'b0;
        if (BLANK_LZ) begin
            case (idx_nxt)
                2'd1:    blank_nxt = (bcd[15:4] == 12'd0);
                2'd2:    blank_nxt = (bcd[15:8] == 8'd0);
                2'd3:    blank_nxt = (bcd[15:12] == 4'd0);
                default: blank_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tick_d  <= 1'b0;
            idx     <= 2'd0;
            digit   <= 4'd0;
            blank_r <= 1'b1;
            AN      <= 4'b1111;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            tick_d <= tick;
            if (tick) begin
                idx     <= idx_nxt;
                digit   <= bcd[{idx_nxt, 2'b00} +: 4];
                blank_r <= blank_nxt;
            end
            // Anodes follow one clk later to line up with the decoder's register stage.
            if (tick_d) begin
                AN <= blank_r ? 4'b1111 : ~(4'b0001 << idx);
            end
        end
    end

endmodule
